// File: rtl/alu_accum_sequencer.sv
// Sequencer in front of a 4-bit add/sub ALU: accepts LOAD/ADD/SUB/CLEAR, keeps a 4-bit accumulator.
// Latency: LOAD/CLEAR result valid 1 edge after accept, ADD/SUB 2 edges (one EXEC cycle through the ALU).
// Backpressure: op_ready only in IDLE; the result is held stable in RESP until res_ready completes the handshake.
module alu_accum_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_cmd,
  input  logic [3:0]       op_data,
  output logic [3:0]       alu_in1,
  output logic [3:0]       alu_in2,
  output logic             alu_s,
  input  logic [3:0]       alu_out,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_ADD   = 2'b01;
  localparam logic [1:0] CMD_SUB   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  logic [1:0]       state;
  logic [1:0]       cmd_r;
  logic [3:0]       acc;
  logic [3:0]       opnd_r;
  logic             alu_s_r;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             res_hs;

  // Handshakes decode only from registered state, so no input-to-ready/valid combinational path.
  assign op_ready  = (state == IDLE);
  assign res_valid = (state == RESP);
  assign accept    = op_valid && op_ready;
  assign res_hs    = res_valid && res_ready;

  assign alu_in1  = acc;
  assign alu_in2  = opnd_r;
  assign alu_s    = alu_s_r;
  assign op_count = cnt;

  // Control FSM: IDLE accepts, EXEC spends one cycle in the ALU, RESP waits for the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_cmd == CMD_ADD || op_cmd == CMD_SUB) state <= EXEC;
            else                                         state <= RESP;
          end
        end
        EXEC:    state <= RESP;
        RESP:    if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: command/operand capture, accumulator update and result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r     <= CMD_LOAD;
      opnd_r    <= 4'd0;
      acc       <= 4'd0;
      alu_s_r   <= 1'b0;
      res_data  <= 4'd0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        cmd_r  <= op_cmd;
        opnd_r <= op_data;
        case (op_cmd)
          CMD_LOAD: begin
            acc       <= op_data;
            res_data  <= op_data;
            res_carry <= 1'b0;
            res_zero  <= (op_data == 4'd0);
          end
          CMD_CLEAR: begin
            acc       <= 4'd0;
            res_data  <= 4'd0;
            res_carry <= 1'b0;
            res_zero  <= 1'b1;
          end
          default: begin
            // Select is set at accept so it is stable for the whole EXEC cycle.
            alu_s_r <= (op_cmd == CMD_SUB);
          end
        endcase
      end else if (state == EXEC) begin
        acc      <= alu_out;
        res_data <= alu_out;
        res_zero <= (alu_out == 4'd0);
        // ALU reports no borrow when subtracting, so derive it from the operands here.
        if (cmd_r == CMD_SUB) res_carry <= (acc < opnd_r);
        else                  res_carry <= alu_cout;
      end
    end
  end

  // Completed-result counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (res_hs && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_accum_sequencer.sv
module tb_alu_accum_sequencer;

  localparam int CNT_W = 2;

  typedef struct packed {
    logic [3:0] data;
    logic       carry;
    logic       zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [1:0]       op_cmd = 2'b00;
  logic [3:0]       op_data = 4'd0;
  logic [3:0]       alu_in1;
  logic [3:0]       alu_in2;
  logic             alu_s;
  logic [3:0]       alu_out;
  logic             alu_cout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [3:0]       res_data;
  logic             res_carry;
  logic             res_zero;
  logic [CNT_W-1:0] op_count;

  int   tests = 0;
  int   fails = 0;
  res_t sb_q[$];
  logic [3:0] m_acc = 4'd0;
  int   m_cnt = 0;

  alu_accum_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd), .op_data(op_data),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_s(alu_s),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .op_count(op_count)
  );

  // Behavioural 4-bit add/sub ALU; carry forced to 0 when subtracting.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
    if (alu_s) begin
      alu_out  = alu_in1 - alu_in2;
      alu_cout = 1'b0;
    end else begin
      alu_out  = alu_sum[3:0];
      alu_cout = alu_sum[4];
    end
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: compute expected result and push it to the scoreboard.
  task automatic model_push(input logic [1:0] cmd, input logic [3:0] d);
    res_t r;
    logic [4:0] s;
    r.carry = 1'b0;
    case (cmd)
      2'b00: m_acc = d;
      2'b01: begin s = {1'b0, m_acc} + {1'b0, d}; r.carry = s[4]; m_acc = s[3:0]; end
      2'b10: begin r.carry = (m_acc < d); m_acc = m_acc - d; end
      default: m_acc = 4'd0;
    endcase
    r.data = m_acc;
    r.zero = (m_acc == 4'd0);
    sb_q.push_back(r);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_op_ready"}, {7'd0, op_ready}, 8'd1);
    chk({tag, "_res_valid"}, {7'd0, res_valid}, 8'd0);
    chk({tag, "_res_data"}, {4'd0, res_data}, 8'd0);
    chk({tag, "_res_carry"}, {7'd0, res_carry}, 8'd0);
    chk({tag, "_res_zero"}, {7'd0, res_zero}, 8'd0);
    chk({tag, "_alu_in1"}, {4'd0, alu_in1}, 8'd0);
    chk({tag, "_alu_in2"}, {4'd0, alu_in2}, 8'd0);
    chk({tag, "_alu_s"}, {7'd0, alu_s}, 8'd0);
    chk({tag, "_op_count"}, {6'd0, op_count}, 8'd0);
  endtask

  // Assert reset mid-cycle and check outputs before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(tag);
    m_acc = 4'd0;
    m_cnt = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one command and wait for the accept edge; checks EXEC-phase ALU drive for ADD/SUB.
  task automatic send(input string tag, input logic [1:0] cmd, input logic [3:0] d);
    @(negedge clk);
    chk({tag, "_op_ready"}, {7'd0, op_ready}, 8'd1);
    op_valid = 1'b1; op_cmd = cmd; op_data = d;
    model_push(cmd, d);
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (cmd == 2'b01 || cmd == 2'b10) begin
      chk({tag, "_exec_alu_s"}, {7'd0, alu_s}, {7'd0, cmd == 2'b10});
      chk({tag, "_exec_alu_in2"}, {4'd0, alu_in2}, {4'd0, d});
    end
  endtask

  // Called #1 after the accept edge; waits (bounded) for res_valid and compares against the scoreboard.
  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    res_t e;
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 8'(lat), 8'(exp_lat));
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      chk({tag, "_res_data"}, {4'd0, res_data}, {4'd0, e.data});
      chk({tag, "_res_carry"}, {7'd0, res_carry}, {7'd0, e.carry});
      chk({tag, "_res_zero"}, {7'd0, res_zero}, {7'd0, e.zero});
    end else begin
      chk({tag, "_scoreboard_nonempty"}, 8'd0, 8'd1);
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    if (m_cnt < 3) m_cnt++;
    chk({tag, "_op_count"}, {6'd0, op_count}, 8'(m_cnt));
    chk({tag, "_op_ready_after"}, {7'd0, op_ready}, 8'd1);
    chk({tag, "_res_valid_after"}, {7'd0, res_valid}, 8'd0);
  endtask

  task automatic do_op(input string tag, input logic [1:0] cmd, input logic [3:0] d);
    send(tag, cmd, d);
    wait_result(tag, (cmd == 2'b01 || cmd == 2'b10) ? 2 : 1);
    handshake(tag);
  endtask

  initial begin
    res_t hold;
    int cnt_before;

    // Power-up reset, then a mid-cycle asynchronous reset check.
    #3;
    rst_n = 1'b1;
    do_reset("reset");

    // LOAD 9 then ADD 8 -> 1 with carry.
    do_op("load9", 2'b00, 4'h9);
    do_op("add8", 2'b01, 4'h8);

    // Reset during EXEC of an ADD: result discarded, outputs back to reset values.
    send("rst_mid", 2'b01, 4'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    m_acc = 4'd0; m_cnt = 0; sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_result", {7'd0, res_valid}, 8'd0);
    end
    do_op("load2", 2'b00, 4'h2);

    // Backpressure: hold res_ready low for 5 cycles while wiggling the command inputs.
    send("bp_add", 2'b01, 4'h3);
    wait_result("bp_add", 2);
    hold = sb_q[0];
    cnt_before = m_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_valid = ~op_valid;
      op_data  = 4'($urandom_range(0, 15));
      op_cmd   = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      chk("bp_res_valid", {7'd0, res_valid}, 8'd1);
      chk("bp_res_data", {4'd0, res_data}, {4'd0, hold.data});
      chk("bp_res_carry", {7'd0, res_carry}, {7'd0, hold.carry});
      chk("bp_res_zero", {7'd0, res_zero}, {7'd0, hold.zero});
      chk("bp_op_ready", {7'd0, op_ready}, 8'd0);
      chk("bp_op_count", {6'd0, op_count}, 8'(cnt_before));
    end
    @(negedge clk);
    op_valid = 1'b0;
    handshake("bp_add");

    // Subtraction with and without borrow.
    do_op("load3a", 2'b00, 4'h3);
    do_op("sub5", 2'b10, 4'h5);
    do_op("load3b", 2'b00, 4'h3);
    do_op("sub3", 2'b10, 4'h3);

    // Counter saturation with five CLEARs after a fresh reset: 1,2,3,3,3.
    do_reset("reset2");
    for (int i = 0; i < 5; i++) do_op($sformatf("clear%0d", i), 2'b11, 4'hA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
